hamming74_rr_scheduler: RTL

//  Shares one Hamming(7,4) single-error corrector among NREQ requesters.
//  - Round-robin arbitration; valid/ready handshake on the input and output sides.
//  - Registers the corrected nibble, syndrome and requester ID into a one-entry output stage.
//  - Sits between the serial-link deframers and the payload FIFO; replaces per-lane decoder copies.

---
 rtl/hamming74_rr_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/hamming74_rr_scheduler.sv
// hamming74_rr_scheduler: round-robin shared Hamming(7,4) corrector with one-entry output stage; HAMMING_PERREQ_CNT_EN adds per-requester error counters
module hamming74_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_code,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic [IDW-1:0]    out_id,
  output logic [2:0]        out_syn,
  output logic [CNT_W-1:0]  err_count
`ifdef HAMMING_PERREQ_CNT_EN
  ,
  output logic [CNT_W*NREQ-1:0] err_count_req
`endif
);
  logic [IDW-1:0] ptr, gidx;
  logic [IDW:0] off, sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic found, free, accept;
  logic [6:0] y, fix, c;
  logic [2:0] syn;
  assign dbl = {req_valid, req_valid} >> ptr;
  assign rot = dbl[NREQ-1:0];
  // first valid requester at or after ptr, as an offset from ptr
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && rot[k]) begin
        found = 1'b1;
        off = (IDW+1)'(k);
      end
  end
  assign sum = {1'b0, ptr} + off;
  assign gidx = IDW'(sum >= (IDW+1)'(NREQ) ? sum - (IDW+1)'(NREQ) : sum);
  assign free = !out_valid || out_ready;
  assign accept = free && found;
  assign req_ready = accept ? (NREQ'(1) << gidx) : '0;
  assign y = req_code[7*gidx +: 7];
  assign syn = {y[5]^y[4]^y[3]^y[2], y[6]^y[5]^y[3]^y[1], y[6]^y[4]^y[3]^y[0]};
  assign fix = syn == 3'b001 ? 7'h01 :
               syn == 3'b010 ? 7'h02 :
               syn == 3'b100 ? 7'h04 :
               syn == 3'b111 ? 7'h08 :
               syn == 3'b101 ? 7'h10 :
               syn == 3'b110 ? 7'h20 :
               syn == 3'b011 ? 7'h40 : 7'h00;
  assign c = y ^ fix;
  // output stage, rotating pointer and aggregate saturating error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_syn <= '0;
      out_id <= '0;
      ptr <= '0;
      err_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data <= c[6:3];
      out_syn <= syn;
      out_id <= gidx;
      ptr <= gidx == IDW'(NREQ-1) ? '0 : gidx + IDW'(1);
      if (|syn && !(&err_count)) err_count <= err_count + CNT_W'(1);
    end else if (out_ready) out_valid <= 1'b0;
  end
`ifdef HAMMING_PERREQ_CNT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // saturating corrected-word counter for requester i
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (accept && gidx == IDW'(i) && |syn && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
    assign err_count_req[CNT_W*i +: CNT_W] = cnt;
  end
`endif
endmodule
